// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: registered state, combinational Moore controls plus
// ALU/flag decode, raw PCS/NoWrite generation for the downstream condition logic.
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic       NextPC,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       NoWrite,
  output logic [1:0] FlagW,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } stateT;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  stateT      state, nextState;
  logic       branch, aluDecode, supported, flagArith;
  logic [3:0] cmd;

  assign cmd = Funct[4:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  // Next-state and Moore outputs; unused encodings leave every enable low.
  always_comb begin
    nextState = FETCH;
    branch    = 1'b0;
    aluDecode = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    NextPC    = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state)
      FETCH: begin
        nextState = DECODE;
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b00:   nextState = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   nextState = MEMADR;
          2'b10:   nextState = BRANCH;
          default: nextState = FETCH;
        endcase
      end
      MEMADR: begin
        nextState = Funct[0] ? MEMREAD : MEMWRITE;
        ALUSrcB   = 2'b01;
      end
      MEMREAD: begin
        nextState = MEMWB;
        AdrSrc    = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: begin
        nextState = ALUWB;
        aluDecode = 1'b1;
      end
      EXECUTEI: begin
        nextState = ALUWB;
        ALUSrcB   = 2'b01;
        aluDecode = 1'b1;
      end
      ALUWB: begin
        RegW = 1'b1;
      end
      BRANCH: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: nextState = FETCH;
    endcase
  end

  // ALU decode: unsupported commands add (00) and never update flags.
  always_comb begin
    ALUControl = 2'b00;
    FlagW      = 2'b00;
    supported  = 1'b1;
    flagArith  = 1'b0;
    case (cmd)
      CMD_ADD: flagArith = 1'b1;
      CMD_SUB: begin ALUControl = 2'b01; flagArith = 1'b1; end
      CMD_CMP: begin ALUControl = 2'b01; flagArith = 1'b1; end
      CMD_AND: ALUControl = 2'b10;
      CMD_ORR: ALUControl = 2'b11;
      default: supported = 1'b0;
    endcase
    if (!aluDecode) ALUControl = 2'b00;
    if (aluDecode && supported) FlagW = {Funct[0], Funct[0] & flagArith};
  end

  assign NoWrite = (Op == 2'b00) && ((cmd == CMD_CMP) || !supported);
  assign PCS     = branch | (RegW & (Rd == 4'hF));
  assign State   = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: directed instructions push hand-computed
// per-cycle control vectors; a negedge monitor pops and compares them.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b000000;
  logic [3:0] Rd = 4'h0;
  logic       PCS, RegW, MemW, NextPC, IRWrite, AdrSrc, NoWrite;
  logic [1:0] FlagW, ALUSrcA, ALUSrcB, ResultSrc, ALUControl;
  logic [3:0] State;

  int   testsRun = 0;
  int   testsFailed = 0;
  logic checkEn = 1'b0;

  logic [20:0] expQ[$];
  string       nameQ[$];

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .PCS(PCS), .RegW(RegW), .MemW(MemW), .NextPC(NextPC), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .NoWrite(NoWrite), .FlagW(FlagW), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .State(State)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Packed layout: State, {PCS,RegW,MemW,NextPC,IRWrite,AdrSrc,NoWrite}, FlagW, SrcA, SrcB, ResultSrc, ALUControl
  function automatic logic [20:0] mk(input logic [3:0] st, input logic [6:0] en,
                                     input logic [1:0] fw, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] r,
                                     input logic [1:0] alu);
    return {st, en, fw, a, b, r, alu};
  endfunction

  function automatic logic [20:0] actual();
    return {State, PCS, RegW, MemW, NextPC, IRWrite, AdrSrc, NoWrite,
            FlagW, ALUSrcA, ALUSrcB, ResultSrc, ALUControl};
  endfunction

  task automatic push(input string nm, input logic [20:0] v);
    expQ.push_back(v);
    nameQ.push_back(nm);
  endtask

  task automatic pushFetchDecode(input string nm, input logic nw);
    push({nm, ".fetch"},  mk(4'd0, {6'b000110, nw}, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00));
    push({nm, ".decode"}, mk(4'd1, {6'b000000, nw}, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00));
  endtask

  task automatic checkValue(input string nm, input logic [20:0] act, input logic [20:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [20:0] exp;
    string       nm;
    if (expQ.size() == 0) begin
      checkValue("scoreboard_underflow", actual(), 21'h1FFFFF);
    end else begin
      exp = expQ.pop_front();
      nm  = nameQ.pop_front();
      checkValue(nm, actual(), exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) checkOutput();
  end

  // Called one step after an edge with the FSM in FETCH; runs n cycles.
  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct,
                               input logic [3:0] rd, input int n);
    Op      = op;
    Funct   = funct;
    Rd      = rd;
    checkEn = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held across clock edges keeps FETCH.
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset_state", {17'd0, State}, 21'd0);
    checkValue("reset_enables", {14'd0, RegW, MemW, PCS, AdrSrc, NoWrite, FlagW},
               {14'd0, 5'b00000, 2'b00});
    reset = 1'b0;

    pushFetchDecode("ldr", 1'b0);
    push("ldr.memadr",  mk(4'd2, 7'b0000000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
    push("ldr.memread", mk(4'd3, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    push("ldr.memwb",   mk(4'd4, 7'b0100000, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
    applyStimulus(2'b01, 6'b011001, 4'h3, 5);

    pushFetchDecode("str", 1'b0);
    push("str.memadr",   mk(4'd2, 7'b0000000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
    push("str.memwrite", mk(4'd5, 7'b0010010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    applyStimulus(2'b01, 6'b011000, 4'h3, 4);

    pushFetchDecode("cmpi", 1'b1);
    push("cmpi.execi", mk(4'd7, 7'b0000001, 2'b11, 2'b00, 2'b01, 2'b00, 2'b01));
    push("cmpi.aluwb", mk(4'd8, 7'b0100001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    applyStimulus(2'b00, 6'b110101, 4'h0, 4);

    pushFetchDecode("addpc", 1'b0);
    push("addpc.execr", mk(4'd6, 7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    push("addpc.aluwb", mk(4'd8, 7'b1100000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    applyStimulus(2'b00, 6'b001000, 4'hF, 4);

    pushFetchDecode("subis", 1'b0);
    push("subis.execi", mk(4'd7, 7'b0000000, 2'b11, 2'b00, 2'b01, 2'b00, 2'b01));
    push("subis.aluwb", mk(4'd8, 7'b0100000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    applyStimulus(2'b00, 6'b100101, 4'h2, 4);

    pushFetchDecode("ands", 1'b0);
    push("ands.execr", mk(4'd6, 7'b0000000, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10));
    push("ands.aluwb", mk(4'd8, 7'b0100000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    applyStimulus(2'b00, 6'b000001, 4'h4, 4);

    pushFetchDecode("orrs", 1'b0);
    push("orrs.execr", mk(4'd6, 7'b0000000, 2'b10, 2'b00, 2'b00, 2'b00, 2'b11));
    push("orrs.aluwb", mk(4'd8, 7'b0100000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    applyStimulus(2'b00, 6'b011001, 4'h5, 4);

    pushFetchDecode("unsup", 1'b1);
    push("unsup.execr", mk(4'd6, 7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    push("unsup.aluwb", mk(4'd8, 7'b0100001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    applyStimulus(2'b00, 6'b000011, 4'h6, 4);

    pushFetchDecode("ldrpc", 1'b0);
    push("ldrpc.memadr",  mk(4'd2, 7'b0000000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
    push("ldrpc.memread", mk(4'd3, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    push("ldrpc.memwb",   mk(4'd4, 7'b1100000, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
    applyStimulus(2'b01, 6'b011001, 4'hF, 5);

    pushFetchDecode("branch", 1'b0);
    push("branch.br", mk(4'd9, 7'b1000000, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00));
    applyStimulus(2'b10, 6'b000000, 4'h0, 3);

    pushFetchDecode("undef", 1'b0);
    applyStimulus(2'b11, 6'b000000, 4'h0, 2);

    pushFetchDecode("after_undef", 1'b0);
    applyStimulus(2'b11, 6'b000000, 4'h0, 2);

    // Reset arriving mid-cycle in MEMWRITE must clear state and MemW before the next edge.
    checkEn = 1'b0;
    Op      = 2'b01;
    Funct   = 6'b011000;
    Rd      = 4'h1;
    repeat (3) @(posedge clk);
    #2;
    checkValue("mid_pre_state", {17'd0, State}, 21'd5);
    checkValue("mid_pre_memw", {20'd0, MemW}, 21'd1);
    reset = 1'b1;
    #1;
    checkValue("mid_reset_state", {17'd0, State}, 21'd0);
    checkValue("mid_reset_memw", {19'd0, MemW, RegW}, 21'd0);
    @(posedge clk);
    #1;
    checkValue("reset_hold_state", {17'd0, State}, 21'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkValue("release_state", {17'd0, State}, 21'd1);

    checkValue("scoreboard_leftover", 21'(expQ.size()), 21'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port Op, input, 2 bits: instruction bits [27:26] from IR.
REQ-004 SHALL have port Funct, input, 6 bits: instruction bits [25:20] (I, cmd[3:0], S).
REQ-005 SHALL have port Rd, input, 4 bits: instruction bits [15:12].
REQ-006 SHALL have ports PCS, RegW, MemW, NextPC, IRWrite, AdrSrc, NoWrite, outputs, 1 bit each: raw (unconditioned) controls for the condition-logic block.
REQ-007 SHALL have ports FlagW, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, outputs, 2 bits each.
REQ-008 SHALL have port State, output, 4 bits: current state encoding, for debug.

Function
REQ-009 SHALL use state encodings FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
REQ-010 SHALL transition FETCH->DECODE unconditionally.
REQ-011 SHALL transition from DECODE on Op: 00 with Funct[5]=0 ->EXECUTER, 00 with Funct[5]=1 ->EXECUTEI, 01->MEMADR, 10->BRANCH, 11->FETCH (undefined op, no side effects).
REQ-012 SHALL transition MEMADR->MEMREAD if Funct[0]=1, else ->MEMWRITE; MEMREAD->MEMWB; EXECUTER/EXECUTEI->ALUWB; MEMWB, MEMWRITE, ALUWB, BRANCH ->FETCH.
REQ-013 SHALL decode any unused state encoding (10-15) as FETCH on the next edge, with all enables 0 in that cycle.
REQ-014 SHALL drive Moore outputs per state as follows; any output not listed is 0.
- FETCH: AdrSrc=0, IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALU op ADD.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcA=00, ALUSrcB=01, ALU op ADD.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWRITE: AdrSrc=1, MemW=1.
- EXECUTER: ALUSrcA=00, ALUSrcB=00, ALU decode active.
- EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALU decode active.
- ALUWB: ResultSrc=00, RegW=1.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, ALU op ADD, internal Branch=1.
REQ-015 SHALL, when ALU decode is active, map cmd=Funct[4:1] as follows.
- ADD(0100)->ALUControl 00.
- SUB(0010)->01.
- AND(0000)->10.
- ORR(1100)->11.
- CMP(1010)->01.
- Any other cmd->00 with FlagW=00.
REQ-016 SHALL set FlagW[1]=Funct[0] and FlagW[0]=Funct[0]&(cmd is ADD, SUB or CMP), only in EXECUTER/EXECUTEI; FlagW=00 in all other states.
REQ-017 SHALL drive ALUControl=00 whenever ALU decode is inactive.
REQ-018 SHALL drive NoWrite=1 in every state when Op=00 and cmd=CMP or cmd is unsupported, else 0.
REQ-019 SHALL drive PCS=Branch | (RegW & Rd==1111) combinationally, in every state.
REQ-020 SHALL register state only; decode outputs are combinational from State, Op, Funct and Rd, with zero-cycle latency.
REQ-021 SHALL complete an instruction in the following cycles: load 5, store 4, data-processing 4, branch 3, undefined 2.

Reset
REQ-022 SHALL force State=FETCH immediately on reset assertion, independent of clk.
REQ-023 SHALL hold FETCH while reset=1; the first edge after deassertion moves to DECODE.
REQ-024 SHALL abandon the current instruction on reset mid-instruction; no RegW/MemW is issued after reset asserts.

Verification
REQ-025 SHALL verify: reset, release, Op=01, Funct=011001 (LDR) -> states 0,1,2,3,4,0; RegW=1 only in state 4, ResultSrc=01 there.
REQ-026 SHALL verify: Op=01, Funct=011000 (STR) -> states 0,1,2,5,0; MemW=1 only in state 5, AdrSrc=1.
REQ-027 SHALL verify: Op=00, Funct=110101 (CMP imm, S=1) -> EXECUTEI with ALUControl=01, FlagW=11; ALUWB with RegW=1, NoWrite=1.
REQ-028 SHALL verify: Op=00, Funct=001000 (ADD reg, S=0), Rd=1111 -> FlagW=00 in EXECUTER; PCS=1 in ALUWB.
REQ-029 SHALL verify: Op=10 -> BRANCH with PCS=1, ALUSrcA=10, then FETCH; Op=11 -> DECODE->FETCH with no enables.
REQ-030 SHALL verify: reset asserted mid-cycle while in MEMWRITE -> State=0 and MemW=0 before the next clk edge.
